alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, multi-cycle successor to the team's 32-bit single-cycle ALU. It keeps the existing 3-bit operation codes and zero/negative flags, and adds:
- logical right shift;
- overflow-correct signed set-on-less-than;
- iterative unsigned multiply and divide producing HI/LO results.

It sits in the EX stage of the multi-cycle datapath. The control FSM issues `start` and stalls on `busy` until `done`.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width; must be a power of two, ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width (derived, not overridden).

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only while `busy`=0
- `op`  in  4  operation: {1'b0, legacy gin} or extended code
- `a`, `b`  in  WIDTH  operands, sampled with `start`
- `busy`  out  1  iteration in progress
- `done`  out  1  one-cycle pulse; results valid from this cycle
- `result`  out  WIDTH  primary result
- `hi`, `lo`  out  WIDTH  multiply/divide result pair
- `zout`  out  1  `result` == 0
- `nout`  out  1  `result[WIDTH-1]`
- `div0`  out  1  last DIVU had `b`==0

## Operation
Op codes:
- 0000 AND; 0001 OR; 0010 ADD; 0110 SUB.
- 0111 SLT: signed compare; `result`=1 if a<b, else 0; correct under overflow.
- 0100 SLLV: a << b[SHW-1:0].
- 0101 SRLV: a >> b[SHW-1:0], logical.
- 1000 MULTU: {hi,lo} = a*b, unsigned 2·WIDTH-bit product; `result`=lo.
- 1001 DIVU: lo = a/b, hi = a%b, unsigned; `result`=lo.
- Any other code: `result`=0, `hi`/`lo` unchanged, completes as a single-cycle op.

Arithmetic:
- ADD and SUB wrap modulo 2^WIDTH; no overflow output.

Registered outputs:
- `result`, `hi`, `lo`, `zout`, `nout` and `div0` are registered.
- They hold their values until the next accepted op completes.
- `hi`/`lo` change only on MULTU or DIVU.
- `div0` updates only on DIVU.

DIVU with `b`=0:
- lo = all ones, hi = a, `div0`=1.
- Completes as a single-cycle op.

FSM states:
- IDLE: on `start` with a single-cycle op (or DIVU with b=0), compute, register results, pulse `done` next cycle, stay IDLE. On `start` with MULTU/DIVU, load the operand and accumulator registers, clear the counter, go to ITER.
- ITER: `busy`=1. One shift-add (MULTU) or restoring subtract-shift (DIVU) step per cycle. After WIDTH steps, register results, go to FIN.
- FIN: `done`=1, `busy`=0. A `start` in this cycle is accepted exactly as in IDLE. Otherwise return to IDLE.

Boundary rules:
- `start` while `busy`=1 is ignored, and is not queued.
- `op`, `a`, `b` may change freely after acceptance.

## Timing
Reset:
- `rst_n` low, at any time including mid-ITER, asynchronously forces state IDLE.
- All outputs go to 0 (`zout`=0 included), the counter clears and the in-flight op is discarded.
- The first `start` after `rst_n` rises is accepted normally.

Latency, with `start` accepted at edge N:
- Single-cycle ops: `done` high in cycle N+1; `busy` never asserted.
- MULTU/DIVU (b≠0): `busy` high in cycles N+1..N+WIDTH; `done` high in cycle N+WIDTH+1, with `busy` low.

Throughput:
- Back-to-back single-cycle ops: one per cycle.
- Iterative ops: one per WIDTH+1 cycles, since the FIN cycle accepts the next op.

## Structure
- Package `alu_seq_pkg` holds:
  - the op-code localparams / enum (`OP_AND` … `OP_DIVU`);
  - the state enum {IDLE, ITER, FIN}.
- Sub-module `alu_seq_comb` is parametrised by WIDTH. It produces the single-cycle result for ops 0000–0111, and zero for other codes.
- The top level holds the FSM, the iteration counter and the multiply/divide datapath.

## Test plan
- ADD, a=0x7FFFFFFF, b=1 → `result`=0x80000000, `nout`=1, `zout`=0, `done` at N+1.
- SLT:
  - a=0x80000000, b=1 → `result`=1.
  - a=0x7FFFFFFF, b=0x80000000 → `result`=0.
  - SUB a=5, b=5 → `zout`=1.
- MULTU, a=b=0xFFFFFFFF → `busy` high for 32 cycles, `done` at N+33, hi=0xFFFFFFFE, lo=0x00000001. A `start` during `busy` is ignored.
- DIVU:
  - a=100, b=7 → lo=14, hi=2, `div0`=0, `done` at N+33.
  - a=100, b=0 → lo=0xFFFFFFFF, hi=100, `div0`=1, `done` at N+1.
- SLLV a=1, b=33 → `result`=2; SRLV a=0x80000000, b=31 → `result`=1, `nout`=0.
- `rst_n` pulsed low at cycle N+10 of a MULTU → all outputs 0 immediately, no `done`. A new ADD 2+3 afterwards → `result`=5 at N'+1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared op codes and FSM states for the sequential ALU.
// No logic here: constants and types only, no latency or backpressure.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLLV  = 4'b0100;
    localparam logic [3:0] OP_SRLV  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIN
    } state_t;

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU result for ops 0000-0111, zero for any other code; purely combinational.
// Latency 0, no flow control: output follows inputs.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    localparam int SHW = $clog2(WIDTH);

    // One extra sign bit keeps the compare correct when a-b overflows.
    logic [WIDTH:0] slt_diff;

    always_comb begin
        slt_diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        result   = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, slt_diff[WIDTH]};
            OP_SLLV: result = a << b[SHW-1:0];
            OP_SRLV: result = a >> b[SHW-1:0];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops done next cycle, MULTU/DIVU done WIDTH+1 cycles after start.
// Backpressure via busy: start is ignored (not queued) while iterating; the done cycle accepts a new op.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zout,
    output logic             nout,
    output logic             div0
);

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // product high half / partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;     // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] opd_q, opd_d;     // multiplicand or divisor
    logic             is_div_q, is_div_d;

    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic             zout_q, zout_d, nout_q, nout_d, div0_q, div0_d, done_q, done_d;
    logic             commit;

    logic [WIDTH-1:0] comb_result;
    logic [WIDTH:0]   mul_sum, div_trial;
    logic [WIDTH-1:0] step_hi, step_lo;

    alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
        .op     (op),
        .a      (a),
        .b      (b),
        .result (comb_result)
    );

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
        div_trial = {acc_q, quo_q[WIDTH-1]} - {1'b0, opd_q};
        if (is_div_q) begin
            if (!div_trial[WIDTH]) begin
                step_hi = div_trial[WIDTH-1:0];
                step_lo = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = {acc_q[WIDTH-2:0], quo_q[WIDTH-1]};
                step_lo = {quo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], quo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        result_d = result_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        zout_d   = zout_q;
        nout_d   = nout_q;
        div0_d   = div0_q;
        commit   = 1'b0;

        case (state_q)
            ITER: begin
                acc_d = step_hi;
                quo_d = step_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    hi_d     = step_hi;
                    lo_d     = step_lo;
                    result_d = step_lo;
                    if (is_div_q) begin
                        div0_d = 1'b0;
                    end
                    commit  = 1'b1;
                    state_d = FIN;
                end
            end
            default: begin
                // IDLE and FIN accept a new op identically.
                state_d = IDLE;
                if (start) begin
                    if (op == OP_MULTU) begin
                        acc_d    = '0;
                        quo_d    = b;
                        opd_d    = a;
                        is_div_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = ITER;
                    end else if (op == OP_DIVU && b != '0) begin
                        acc_d    = '0;
                        quo_d    = a;
                        opd_d    = b;
                        is_div_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = ITER;
                    end else if (op == OP_DIVU) begin
                        lo_d     = '1;
                        hi_d     = a;
                        result_d = '1;
                        div0_d   = 1'b1;
                        commit   = 1'b1;
                    end else begin
                        result_d = comb_result;
                        commit   = 1'b1;
                    end
                end
            end
        endcase

        if (commit) begin
            zout_d = (result_d == '0);
            nout_d = result_d[WIDTH-1];
        end
        done_d = commit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            zout_q   <= 1'b0;
            nout_q   <= 1'b0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            zout_q   <= zout_d;
            nout_q   <= nout_d;
            div0_q   <= div0_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == ITER);
    assign done   = done_q;
    assign result = result_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign zout   = zout_q;
    assign nout   = nout_q;
    assign div0   = div0_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed literal cases plus randomized traffic checked every cycle
// against a transaction-level model (plain arithmetic, countdown for iterative ops).
module tb_alu_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    op = 4'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy, done, zout, nout, div0;
    logic [W-1:0]  result, hi, lo;

    int tests = 0;
    int failed = 0;
    bit check_en = 1'b0;

    alu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .hi     (hi),
        .lo     (lo),
        .zout   (zout),
        .nout   (nout),
        .div0   (div0)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int           m_wait = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_result = '0, m_hi = '0, m_lo = '0;
    logic         m_zout = 1'b0, m_nout = 1'b0, m_div0 = 1'b0;
    logic [W-1:0] p_result, p_hi, p_lo;
    logic         p_div0, p_iter;

    task model_accept(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] prod;
        p_hi = m_hi;
        p_lo = m_lo;
        p_div0 = m_div0;
        p_iter = 1'b0;
        p_result = '0;
        case (o)
            4'b0000: p_result = x & y;
            4'b0001: p_result = x | y;
            4'b0010: p_result = x + y;
            4'b0110: p_result = x - y;
            4'b0111: p_result = ($signed(x) < $signed(y)) ? 1 : 0;
            4'b0100: p_result = x << (y % W);
            4'b0101: p_result = x >> (y % W);
            4'b1000: begin
                prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                p_hi = prod[2*W-1:W];
                p_lo = prod[W-1:0];
                p_result = p_lo;
                p_iter = 1'b1;
            end
            4'b1001: begin
                if (y == 0) begin
                    p_lo = '1;
                    p_hi = x;
                    p_div0 = 1'b1;
                end else begin
                    p_lo = x / y;
                    p_hi = x % y;
                    p_div0 = 1'b0;
                    p_iter = 1'b1;
                end
                p_result = p_lo;
            end
            default: p_result = '0;
        endcase
    endtask

    task model_commit;
        m_result = p_result;
        m_hi = p_hi;
        m_lo = p_lo;
        m_div0 = p_div0;
        m_zout = (p_result == 0);
        m_nout = p_result[W-1];
        m_done = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wait = 0; m_done = 1'b0;
            m_result = '0; m_hi = '0; m_lo = '0;
            m_zout = 1'b0; m_nout = 1'b0; m_div0 = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) model_commit();
            end else if (start === 1'b1) begin
                model_accept(op, a, b);
                if (p_iter) m_wait = W;
                else model_commit();
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_busy",   {31'b0, busy},   {31'b0, (m_wait != 0)});
            chk("cyc_done",   {31'b0, done},   {31'b0, m_done});
            chk("cyc_result", result,          m_result);
            chk("cyc_hi",     hi,              m_hi);
            chk("cyc_lo",     lo,              m_lo);
            chk("cyc_zout",   {31'b0, zout},   {31'b0, m_zout});
            chk("cyc_nout",   {31'b0, nout},   {31'b0, m_nout});
            chk("cyc_div0",   {31'b0, div0},   {31'b0, m_div0});
        end
    end

    // ---------------- directed stimulus ----------------
    // Issues one op, returns cycles from acceptance edge to done and busy-cycle count.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit poke, output int lat, output int nbusy);
        @(posedge clk); #1;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        nbusy = 0;
        while (!done && lat < 100) begin
            if (busy) nbusy++;
            if (poke && lat == 5) begin
                start = 1'b1; op = 4'b0010; a = 1; b = 1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_hi"}, hi, 0);
        chk({tag, "_lo"}, lo, 0);
        chk({tag, "_zout"}, {31'b0, zout}, 0);
        chk({tag, "_nout"}, {31'b0, nout}, 0);
        chk({tag, "_div0"}, {31'b0, div0}, 0);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_done"}, {31'b0, done}, 0);
    endtask

    initial begin
        int lat, nb;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("rst");
        rst_n = 1'b1;
        check_en = 1'b1;

        run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b0, lat, nb);
        chk("add_lat", lat, 1);
        chk("add_busy", nb, 0);
        chk("add_result", result, 32'h8000_0000);
        chk("add_nout", {31'b0, nout}, 1);
        chk("add_zout", {31'b0, zout}, 0);

        run_op(4'b0111, 32'h8000_0000, 32'h1, 1'b0, lat, nb);
        chk("slt_neg", result, 1);
        run_op(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, lat, nb);
        chk("slt_ovf", result, 0);
        run_op(4'b0110, 32'd5, 32'd5, 1'b0, lat, nb);
        chk("sub_zout", {31'b0, zout}, 1);

        run_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, nb);
        chk("mul_lat", lat, 33);
        chk("mul_busy", nb, 32);
        chk("mul_hi", hi, 32'hFFFF_FFFE);
        chk("mul_lo", lo, 32'h0000_0001);
        chk("mul_result", result, 32'h0000_0001);

        run_op(4'b1001, 32'd100, 32'd7, 1'b0, lat, nb);
        chk("div_lat", lat, 33);
        chk("div_lo", lo, 14);
        chk("div_hi", hi, 2);
        chk("div_div0", {31'b0, div0}, 0);

        run_op(4'b1001, 32'd100, 32'd0, 1'b0, lat, nb);
        chk("div0_lat", lat, 1);
        chk("div0_lo", lo, 32'hFFFF_FFFF);
        chk("div0_hi", hi, 100);
        chk("div0_flag", {31'b0, div0}, 1);

        run_op(4'b0100, 32'd1, 32'd33, 1'b0, lat, nb);
        chk("sllv", result, 2);
        run_op(4'b0101, 32'h8000_0000, 32'd31, 1'b0, lat, nb);
        chk("srlv", result, 1);
        chk("srlv_nout", {31'b0, nout}, 0);

        // Reset in the middle of a multiply.
        @(posedge clk); #1;
        op = 4'b1000; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(4'b0010, 32'd2, 32'd3, 1'b0, lat, nb);
        chk("post_rst_lat", lat, 1);
        chk("post_rst_add", result, 5);

        // Randomized traffic, including starts during busy and in the done cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) != 0);
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = $urandom_range(0, 3);
                1: b = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = $urandom_range(1, 65535);
                default: b = $urandom;
            endcase
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
